mux_4x1: RTL and testbench

//   4-to-1 selector: routes one of four W-bit data inputs to the output, chosen by a 2-bit select.

---
 rtl/mux_4x1.sv | 82 ++++++++
 tb/tb_mux_4x1.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mux_4x1.sv
// 4-to-1 W-bit lane selector with a registered copy; optional per-lane selection counters (MUX_4X1_STATS_EN).
// Latency: y is combinational (0 cycles); y_q/sel_q follow one cycle later when en=1.
// Backpressure: none; en=0 simply holds the registered outputs and counters.
module mux_4x1 #(
    parameter int W = 1
`ifdef MUX_4X1_STATS_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [4*W-1:0]   i,
    input  logic [1:0]       sel,
    output logic [W-1:0]     y,
    output logic [W-1:0]     y_q,
    output logic [1:0]       sel_q
`ifdef MUX_4X1_STATS_EN
    ,
    output logic [4*CNT_W-1:0] cnt_k
`endif
);

    logic [W-1:0] y_d;
    logic [1:0]   sel_d;

    // Every select code maps to a lane; x/z on the chosen lane passes straight through.
    always_comb begin
        y = i[0 +: W];
        case (sel)
            2'd0: y = i[0*W +: W];
            2'd1: y = i[1*W +: W];
            2'd2: y = i[2*W +: W];
            2'd3: y = i[3*W +: W];
            default: y = i[0 +: W];
        endcase
    end

    always_comb begin
        y_d   = y_q;
        sel_d = sel_q;
        if (en) begin
            y_d   = y;
            sel_d = sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= '0;
            sel_q <= 2'd0;
        end else begin
            y_q   <= y_d;
            sel_q <= sel_d;
        end
    end

`ifdef MUX_4X1_STATS_EN
    logic [3:0][CNT_W-1:0] cnt_q;
    logic [3:0][CNT_W-1:0] cnt_d;

    // Only the selected lane's counter moves, and it sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q[sel] != {CNT_W{1'b1}})) begin
            cnt_d[sel] = cnt_q[sel] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_k = cnt_q;
`endif

endmodule

// File: tb/tb_mux_4x1.sv
// Directed and randomized checks of mux_4x1 against a lane-shift reference model.
module tb_mux_4x1;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] i;
    logic [1:0] sel;
    logic       y;
    logic       y_q;
    logic [1:0] sel_q;
`ifdef MUX_4X1_STATS_EN
    logic [31:0] cnt_k;
`endif

    int checks = 0;
    int errors = 0;

    logic       m_yq;
    logic [1:0] m_selq;
    int         m_cnt [4];

    mux_4x1 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .i     (i),
        .sel   (sel),
        .y     (y),
        .y_q   (y_q),
        .sel_q (sel_q)
`ifdef MUX_4X1_STATS_EN
        ,
        .cnt_k (cnt_k)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic model_y(input logic [3:0] iv, input logic [1:0] s);
        logic [3:0] sh;
        sh = iv >> s;
        return sh[0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_yq   = 1'b0;
        m_selq = 2'd0;
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    endtask

    // Advance the model with the inputs present at the edge, then sample 1 time unit after it.
    task automatic tick();
        if (rst_n && en) begin
            m_yq   = model_y(i, sel);
            m_selq = sel;
            if (m_cnt[sel] < 255) m_cnt[sel] = m_cnt[sel] + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_y_q"}, {31'd0, y_q}, {31'd0, m_yq});
        chk({tag, "_sel_q"}, {30'd0, sel_q}, {30'd0, m_selq});
`ifdef MUX_4X1_STATS_EN
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_cnt%0d", tag, k), {24'd0, cnt_k[k*8 +: 8]}, m_cnt[k]);
`endif
    endtask

    initial begin
        logic [3:0] sweep_i [7];
        logic [1:0] sweep_s [7];
        logic       sweep_y [7];
        sweep_i = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1100, 4'b1111, 4'b0010};
        sweep_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
        sweep_y = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset state, held across clocks even with en=1 and live data.
        rst_n = 1'b0; en = 1'b0; i = 4'b0000; sel = 2'd0;
        model_reset();
        #1;
        chk("rst_y", {31'd0, y}, 32'd0);
        chk_regs("rst");
        en = 1'b1; i = 4'b1111; sel = 2'd3;
        repeat (3) tick();
        chk_regs("rst_hold");
        chk("rst_y_live", {31'd0, y}, 32'd1);

        // Combinational sweep, no clock edge between set and check.
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            i = sweep_i[k]; sel = sweep_s[k];
            #1;
            chk($sformatf("sweep%0d", k), {31'd0, y}, {31'd0, sweep_y[k]});
        end

        // Register path capture and hold.
        en = 1'b1; i = 4'b0100; sel = 2'd2;
        tick();
        chk("reg_y_q", {31'd0, y_q}, 32'd1);
        chk("reg_sel_q", {30'd0, sel_q}, 32'd2);
        chk_regs("reg");
        en = 1'b0; sel = 2'd0;
        #1;
        chk("hold_y", {31'd0, y}, 32'd0);
        chk_regs("hold_now");
        tick();
        chk_regs("hold_edge");

        // Asynchronous reset between edges.
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_y_q", {31'd0, y_q}, 32'd0);
        chk("arst_sel_q", {30'd0, sel_q}, 32'd0);
        chk_regs("arst");
        i = 4'b0001;
        #1;
        chk("arst_y_tracks", {31'd0, y}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive combinational map.
        for (int a = 0; a < 16; a++) begin
            for (int s = 0; s < 4; s++) begin
                i = 4'(a); sel = 2'(s);
                #1;
                chk($sformatf("exh_i%0d_s%0d", a, s), {31'd0, y}, {31'd0, model_y(i, sel)});
            end
        end

`ifdef MUX_4X1_STATS_EN
        // Saturation on lane 1, then hold with en=0.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        rst_n = 1'b1;
        en = 1'b1; sel = 2'd1; i = 4'b0010;
        repeat (300) tick();
        chk("sat_lane1", {24'd0, cnt_k[15:8]}, 32'd255);
        chk("sat_lane0", {24'd0, cnt_k[7:0]}, 32'd0);
        chk("sat_lane2", {24'd0, cnt_k[23:16]}, 32'd0);
        chk("sat_lane3", {24'd0, cnt_k[31:24]}, 32'd0);
        en = 1'b0; sel = 2'd2;
        repeat (5) tick();
        chk_regs("sat_hold");
`endif

        // Randomized traffic with occasional mid-cycle resets.
        for (int n = 0; n < 400; n++) begin
            i   = 4'($urandom);
            sel = 2'($urandom);
            en  = ($urandom_range(0, 3) != 0);
            #1;
            chk($sformatf("rnd%0d_y", n), {31'd0, y}, {31'd0, model_y(i, sel)});
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                chk_regs($sformatf("rnd%0d_arst", n));
                rst_n = 1'b1;
            end
            tick();
            chk_regs($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
